meas_frame_tx: RTL

- Consumes the per-cycle measurement bus produced by the top-level signal-processing core:
  - ADC raw channels
  - science channels
  - OPD, shear and pointing estimates
  - sample counter
- On each sample strobe, snapshots all channels.
- Serializes the snapshot as one framed burst on a valid/ready stream (header word, then one 32-bit word per channel) toward the PS DMA / packet path.
- Transmit end of the measurement interface; the core is the producer.

---
 rtl/meas_frame_pkg.sv | 43 ++++
 rtl/meas_frame_tx_sat_counter.sv | 21 ++
 rtl/meas_frame_tx.sv | 110 +++++++++++
 3 files changed

// File: rtl/meas_frame_pkg.sv
// Shared constants for the measurement frame transmitter: header magic,
// default channel count, FSM state encoding and channel slot indices.
package meas_frame_pkg;

    localparam int          N_CH_DEF = 27;
    localparam logic [15:0] MAGIC    = 16'hA5C3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    // Payload slot of each channel within a frame (word 0 follows the header)
    localparam int CH_ADC_SHEAR1   = 0;
    localparam int CH_ADC_SHEAR2   = 1;
    localparam int CH_ADC_SHEAR3   = 2;
    localparam int CH_ADC_SHEAR4   = 3;
    localparam int CH_ADC_POINT1   = 4;
    localparam int CH_ADC_POINT2   = 5;
    localparam int CH_ADC_POINT3   = 6;
    localparam int CH_ADC_POINT4   = 7;
    localparam int CH_ADC_SINE_REF = 8;
    localparam int CH_ADC_OPD_REF  = 9;
    localparam int CH_ADC_SCI_NULL = 10;
    localparam int CH_ADC_SCI_MOD  = 11;
    localparam int CH_OPD_X        = 12;
    localparam int CH_OPD_Y        = 13;
    localparam int CH_SHEAR_X1     = 14;
    localparam int CH_SHEAR_X2     = 15;
    localparam int CH_SHEAR_Y1     = 16;
    localparam int CH_SHEAR_Y2     = 17;
    localparam int CH_SHEAR_I1     = 18;
    localparam int CH_SHEAR_I2     = 19;
    localparam int CH_POINT_X1     = 20;
    localparam int CH_POINT_X2     = 21;
    localparam int CH_POINT_Y1     = 22;
    localparam int CH_POINT_Y2     = 23;
    localparam int CH_POINT_I1     = 24;
    localparam int CH_POINT_I2     = 25;
    localparam int CH_COUNTER      = 26;

endpackage

// File: rtl/meas_frame_tx_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/meas_frame_tx.sv
// Snapshots the measurement bus on each sample strobe and streams it out as
// one framed burst: {MAGIC, seq} header followed by N_CH 32-bit channel words.
module meas_frame_tx
    import meas_frame_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              sample_valid_i,
    input  logic [N_CH*32-1:0] ch_i,
    output logic [31:0]       m_tdata_o,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic              m_tlast_o,
    output logic              busy_o,
    output logic [15:0]       seq_o,
    output logic [15:0]       dropped_o
);

    localparam int              IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [31:0]      snap [N_CH];

    logic             hs;
    logic             last_hs;
    logic             strobe_en;
    logic             accept;
    logic [15:0]      seq_nxt;
    logic [IDX_W-1:0] idx_nxt;

    assign hs        = m_tvalid_o && m_tready_i;
    assign last_hs   = hs && (state == PAY) && m_tlast_o;
    assign strobe_en = sample_valid_i && enable_i;
    // A new frame may start in the very cycle the previous one hands off its last word
    assign accept    = strobe_en && ((state == IDLE) || last_hs);
    assign seq_nxt   = seq_o + 16'd1;
    assign idx_nxt   = idx + IDX_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            seq_o      <= '0;
            m_tdata_o  <= '0;
            m_tvalid_o <= 1'b0;
            m_tlast_o  <= 1'b0;
            busy_o     <= 1'b0;
            for (int k = 0; k < N_CH; k++) snap[k] <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < N_CH; k++) snap[k] <= ch_i[32*k +: 32];
            end
            if (last_hs) begin
                seq_o <= seq_nxt;
            end

            if (accept) begin
                state      <= HDR;
                idx        <= '0;
                m_tdata_o  <= {MAGIC, (last_hs ? seq_nxt : seq_o)};
                m_tvalid_o <= 1'b1;
                m_tlast_o  <= 1'b0;
                busy_o     <= 1'b1;
            end else if (hs) begin
                case (state)
                    HDR: begin
                        state     <= PAY;
                        idx       <= '0;
                        m_tdata_o <= snap[0];
                        m_tlast_o <= (N_CH == 1);
                    end
                    PAY: begin
                        if (m_tlast_o) begin
                            state      <= IDLE;
                            m_tvalid_o <= 1'b0;
                            m_tlast_o  <= 1'b0;
                            busy_o     <= 1'b0;
                        end else begin
                            idx       <= idx_nxt;
                            m_tdata_o <= snap[idx_nxt];
                            m_tlast_o <= (idx_nxt == LAST_IDX);
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        m_tvalid_o <= 1'b0;
                        m_tlast_o  <= 1'b0;
                        busy_o     <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH(16)
    ) u_dropped (
        .clk  (clk),
        .rst  (rst),
        .inc  (strobe_en && !accept),
        .count(dropped_o)
    );

endmodule
